transpose_buffer: RTL and testbench

TRANSPOSE_BUFFER -- requirements
Module: transpose_buffer

---
 rtl/transpose_buffer_if.sv | 15 +
 rtl/transpose_buffer.sv | 130 +++++++++++++
 tb/tb_transpose_buffer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/transpose_buffer_if.sv
// Valid/ready block stream: one beat carries one row or column of a block,
// plus an end-of-block marker and a per-block sideband.
interface transpose_buffer_if #(
    parameter int DATA_W     = 256,
    parameter int USER_WIDTH = 1
);
    logic                  valid;
    logic                  ready;
    logic [DATA_W-1:0]     data;
    logic                  last;
    logic [USER_WIDTH-1:0] user;

    modport master (output valid, data, last, user, input ready);
    modport slave  (input valid, data, last, user, output ready);
endinterface

// File: rtl/transpose_buffer.sv
// Ping-pong NxN block buffer: rows are written into one bank while the other
// bank is read out either row-wise or column-wise, chosen per block.
module transpose_buffer #(
    parameter int COEF_WIDTH = 32,
    parameter int N          = 8,
    parameter int USER_WIDTH = 1
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               transpose_en,
    transpose_buffer_if.slave  in_t,
    transpose_buffer_if.master out_t,
    output logic               err_last
);
    localparam int RW = $clog2(N);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    typedef logic [COEF_WIDTH-1:0] coef_t;

    // Coefficient storage carries no reset; only the control state does.
    coef_t bank_mem [2][N][N];

    logic [RW-1:0]         wr_row_q, wr_row_d;
    logic [RW-1:0]         rd_row_q, rd_row_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [1:0]            full_q, full_d;
    logic [1:0]            mode_q, mode_d;
    logic [USER_WIDTH-1:0] user_q [2];
    logic [USER_WIDTH-1:0] user_d [2];
    logic                  err_last_q, err_last_d;

    logic                  in_acc;
    logic                  out_acc;
    logic                  wr_at_last;
    logic                  rd_at_last;
    logic [N*COEF_WIDTH-1:0] out_data;

    assign in_t.ready  = !areset && !full_q[wr_bank_q];
    assign in_acc      = in_t.valid && in_t.ready;
    assign out_t.valid = full_q[rd_bank_q];
    assign out_acc     = out_t.valid && out_t.ready;
    assign wr_at_last  = (wr_row_q == LAST_ROW);
    assign rd_at_last  = (rd_row_q == LAST_ROW);

    always_comb begin
        wr_row_d   = wr_row_q;
        rd_row_d   = rd_row_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        full_d     = full_q;
        mode_d     = mode_q;
        user_d     = user_q;
        err_last_d = 1'b0;

        if (in_acc) begin
            // Framing is owned by the row counter; in_t.last only feeds the error flag.
            err_last_d = (in_t.last != wr_at_last);
            if (wr_row_q == '0) begin
                mode_d[wr_bank_q] = transpose_en;
                user_d[wr_bank_q] = in_t.user;
            end
            if (wr_at_last) begin
                wr_row_d          = '0;
                wr_bank_d         = !wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_row_d = wr_row_q + RW'(1);
            end
        end

        // A full bank is never the write target, so both updates touch different banks.
        if (out_acc) begin
            if (rd_at_last) begin
                rd_row_d          = '0;
                rd_bank_d         = !rd_bank_q;
                full_d[rd_bank_q] = 1'b0;
            end else begin
                rd_row_d = rd_row_q + RW'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_row_q   <= '0;
            rd_row_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            full_q     <= '0;
            err_last_q <= 1'b0;
        end else begin
            wr_row_q   <= wr_row_d;
            rd_row_q   <= rd_row_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            full_q     <= full_d;
            err_last_q <= err_last_d;
        end
    end

    always_ff @(posedge aclk) begin
        mode_q <= mode_d;
        user_q <= user_d;
    end

    always_ff @(posedge aclk) begin
        if (in_acc) begin
            for (int c = 0; c < N; c++) begin
                bank_mem[wr_bank_q][wr_row_q][c] <= in_t.data[c*COEF_WIDTH +: COEF_WIDTH];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int c = 0; c < N; c++) begin
            if (mode_q[rd_bank_q]) begin
                out_data[c*COEF_WIDTH +: COEF_WIDTH] = bank_mem[rd_bank_q][c][rd_row_q];
            end else begin
                out_data[c*COEF_WIDTH +: COEF_WIDTH] = bank_mem[rd_bank_q][rd_row_q][c];
            end
        end
    end

    assign out_t.data = out_data;
    assign out_t.last = rd_at_last;
    assign out_t.user = user_q[rd_bank_q];
    assign err_last   = err_last_q;
endmodule

// File: tb/tb_transpose_buffer.sv
// Directed bench for transpose_buffer (N=8, 32-bit coefficients, element(r,c)=base+8*r+c):
// a cycle table for single blocks plus queue-driven multi-block sequences.
module tb_transpose_buffer;
    localparam int N  = 8;
    localparam int CW = 32;
    localparam int DW = N * CW;

    logic aclk = 1'b0;
    logic areset;
    logic transpose_en;
    logic err_last;

    transpose_buffer_if #(.DATA_W(DW), .USER_WIDTH(1)) in_if ();
    transpose_buffer_if #(.DATA_W(DW), .USER_WIDTH(1)) out_if ();

    transpose_buffer #(.COEF_WIDTH(CW), .N(N), .USER_WIDTH(1)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .transpose_en (transpose_en),
        .in_t         (in_if),
        .out_t        (out_if),
        .err_last     (err_last)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit vin; bit ten; bit lst; bit usr; int row; bit ordy;
        bit e_irdy; bit e_ovld; bit e_olast; int e_orow; bit e_mode; bit e_user;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        bit            ten;
        bit            user;
    } beat_t;

    vec_t  tbl [34];
    beat_t inq [$];
    beat_t expq [$];

    bit irdy_h [100];
    bit ovld_h [100];
    int acc_h  [100];
    int last_acc_cyc;
    int first_ovld;
    int errs;

    task automatic chk(input string nm, input logic [263:0] got, input logic [263:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] row_vec(input int base, input int r);
        logic [DW-1:0] v;
        for (int c = 0; c < N; c++) v[c*CW +: CW] = CW'(base + 8*r + c);
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_vec(input int base, input bit mode, input int r);
        logic [DW-1:0] v;
        for (int c = 0; c < N; c++) v[c*CW +: CW] = mode ? CW'(base + 8*c + r) : CW'(base + 8*r + c);
        return v;
    endfunction

    function automatic vec_t mkv(input bit vin, input bit ten, input bit lst, input bit usr,
                                 input int row, input bit ordy, input bit e_irdy, input bit e_ovld,
                                 input bit e_olast, input int e_orow, input bit e_mode, input bit e_user);
        vec_t v;
        v.vin = vin; v.ten = ten; v.lst = lst; v.usr = usr; v.row = row; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_olast = e_olast;
        v.e_orow = e_orow; v.e_mode = e_mode; v.e_user = e_user;
        return v;
    endfunction

    task automatic drive_idle();
        in_if.valid = 1'b0;
        in_if.last  = 1'($urandom_range(0, 1));
        in_if.user  = 1'($urandom_range(0, 1));
        transpose_en = 1'($urandom_range(0, 1));
        for (int c = 0; c < N; c++) in_if.data[c*CW +: CW] = $urandom();
    endtask

    task automatic add_block(input int base, input bit mode, input bit user, input logic [7:0] lastmask);
        beat_t b;
        for (int r = 0; r < N; r++) begin
            b.data = row_vec(base, r); b.last = lastmask[r]; b.ten = mode; b.user = user;
            inq.push_back(b);
            b.data = exp_vec(base, mode, r); b.last = (r == N - 1);
            expq.push_back(b);
        end
    endtask

    task automatic run(input int stall, input int maxc);
        bit            held_v;
        logic [DW-1:0] held_data;
        bit            held_last;
        bit            held_user;
        int            idle;
        int            in_acc;
        held_v = 0; held_data = '0; held_last = 0; held_user = 0;
        idle = 0; in_acc = 0; errs = 0; last_acc_cyc = -1; first_ovld = -1;
        for (int cyc = 0; cyc < maxc; cyc++) begin
            if (inq.size() > 0) begin
                in_if.valid  = 1'b1;
                in_if.data   = inq[0].data;
                in_if.last   = inq[0].last;
                in_if.user   = inq[0].user;
                transpose_en = inq[0].ten;
            end else begin
                drive_idle();
            end
            out_if.ready = (cyc >= stall);
            @(negedge aclk);
            irdy_h[cyc] = in_if.ready;
            ovld_h[cyc] = out_if.valid;
            if (err_last) errs++;
            if (out_if.valid && first_ovld < 0) first_ovld = cyc;
            if (held_v)
                chk("stall_hold", {out_if.valid, out_if.last, out_if.user, out_if.data},
                    {1'b1, held_last, held_user, held_data});
            held_v    = out_if.valid && !out_if.ready;
            held_data = out_if.data;
            held_last = out_if.last;
            held_user = out_if.user;
            if (out_if.valid && out_if.ready) begin
                if (expq.size() == 0) begin
                    chk("extra_out_beat", 1, 0);
                end else begin
                    chk($sformatf("out_data_c%0d", cyc), out_if.data, expq[0].data);
                    chk($sformatf("out_last_c%0d", cyc), out_if.last, expq[0].last);
                    chk($sformatf("out_user_c%0d", cyc), out_if.user, expq[0].user);
                    if (out_if.last && last_acc_cyc < 0) last_acc_cyc = cyc;
                    void'(expq.pop_front());
                end
            end
            if (in_if.valid && in_if.ready) begin
                void'(inq.pop_front());
                in_acc++;
            end
            acc_h[cyc] = in_acc;
            @(posedge aclk); #1;
            if (inq.size() == 0 && expq.size() == 0) begin
                idle++;
                if (idle > 2) break;
            end
        end
        chk("in_drained", inq.size(), 0);
        chk("out_drained", expq.size(), 0);
        inq.delete();
        expq.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int gaps;
        vec_t v;

        for (int k = 0; k < 8; k++) begin
            tbl[k]      = mkv(1, 1, k == 7, 1, k, 1, 1, 0, 0, 0, 0, 0);
            tbl[k + 8]  = mkv(0, 0, 0, 0, 0, 1, 1, 1, k == 7, k, 1, 1);
            tbl[k + 17] = mkv(1, 0, k == 7, 0, k, 1, 1, 0, 0, 0, 0, 0);
            tbl[k + 25] = mkv(0, 0, 0, 0, 0, 1, 1, 1, k == 7, k, 0, 0);
        end
        tbl[16] = mkv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[33] = mkv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

        areset = 1'b1;
        out_if.ready = 1'b0;
        drive_idle();
        repeat (2) @(posedge aclk);
        #1;
        @(negedge aclk);
        chk("rst_in_ready", in_if.ready, 0);
        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_err_last", err_last, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_in_ready", in_if.ready, 1);
        chk("post_rst_out_valid", out_if.valid, 0);
        @(posedge aclk); #1;

        // Single transposed block followed by a single pass-through block.
        for (int k = 0; k < 34; k++) begin
            v = tbl[k];
            if (v.vin) begin
                in_if.valid  = 1'b1;
                in_if.data   = row_vec(0, v.row);
                in_if.last   = v.lst;
                in_if.user   = v.usr;
                transpose_en = v.ten;
            end else begin
                drive_idle();
            end
            out_if.ready = v.ordy;
            @(negedge aclk);
            chk($sformatf("t%0d_in_ready", k), in_if.ready, v.e_irdy);
            chk($sformatf("t%0d_out_valid", k), out_if.valid, v.e_ovld);
            chk($sformatf("t%0d_err_last", k), err_last, 0);
            if (v.e_ovld) begin
                chk($sformatf("t%0d_out_last", k), out_if.last, v.e_olast);
                chk($sformatf("t%0d_out_user", k), out_if.user, v.e_user);
                chk($sformatf("t%0d_out_data", k), out_if.data, exp_vec(0, v.e_mode, v.e_orow));
            end
            @(posedge aclk); #1;
        end

        // Four back-to-back blocks, alternating mode and user.
        add_block(1000, 1, 0, 8'h80);
        add_block(2000, 0, 1, 8'h80);
        add_block(3000, 1, 0, 8'h80);
        add_block(4000, 0, 1, 8'h80);
        run(0, 80);
        chk("b2b_first_valid", first_ovld, 8);
        chk("b2b_in_accepted", acc_h[31], 32);
        gaps = 0;
        for (int c = 0; c < 32; c++) if (!irdy_h[c]) gaps++;
        chk("b2b_in_ready_gaps", gaps, 0);
        gaps = 0;
        for (int c = 8; c < 40; c++) if (!ovld_h[c]) gaps++;
        chk("b2b_out_valid_gaps", gaps, 0);
        chk("b2b_err_pulses", errs, 0);

        // Downstream stalled while three blocks are offered.
        add_block(5000, 1, 1, 8'h80);
        add_block(6000, 0, 0, 8'h80);
        add_block(7000, 1, 1, 8'h80);
        run(30, 90);
        chk("stall_ready_c15", irdy_h[15], 1);
        chk("stall_ready_c16", irdy_h[16], 0);
        chk("stall_ready_c29", irdy_h[29], 0);
        chk("stall_accepted_c29", acc_h[29], 16);
        chk("stall_first_last_cyc", last_acc_cyc, 37);
        chk("stall_ready_c37", irdy_h[37], 0);
        chk("stall_ready_c38", irdy_h[38], 1);

        // in_t_last on row 3 instead of row 7.
        add_block(8000, 1, 0, 8'h08);
        run(0, 40);
        chk("framing_err_pulses", errs, 2);
        chk("framing_first_valid", first_ovld, 8);

        // Reset after five rows of a block.
        out_if.ready = 1'b1;
        gaps = 0;
        for (int r = 0; r < 5; r++) begin
            in_if.valid  = 1'b1;
            in_if.data   = row_vec(9000, r);
            in_if.last   = 1'b0;
            in_if.user   = 1'b1;
            transpose_en = 1'b1;
            @(negedge aclk);
            if (out_if.valid) gaps++;
            @(posedge aclk); #1;
        end
        drive_idle();
        areset = 1'b1;
        @(negedge aclk);
        chk("midrst_in_ready", in_if.ready, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("midrst_ready_after", in_if.ready, 1);
        for (int c = 0; c < 10; c++) begin
            if (out_if.valid) gaps++;
            @(posedge aclk); #1;
            drive_idle();
            @(negedge aclk);
        end
        chk("midrst_no_output", gaps, 0);
        @(posedge aclk); #1;
        add_block(10000, 1, 1, 8'h80);
        run(0, 40);
        chk("midrst_first_valid", first_ovld, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
